hazard_unit: RTL
================

# hazard_unit

Pipeline hazard controller for the five-stage core. Consumes per-stage hazard information (load-use operands, memory handshake waits, execute-stage redirects, multi-cycle mul/div issue) and produces the per-register stall/flush enables `{fd,de,em,mw}` plus PC stall/redirect control. It also owns the two pieces of hazard state:

- the multi-cycle ALU latency counter;
- the deferred-redirect FSM that holds a branch target while an instruction fetch is still in flight.

## Interface
Parameters:
- XLEN, 64, PC/target width
- MUL_LAT, 3, total EX-stage cycles for a multiply (≥2)
- DIV_LAT, 33, total EX-stage cycles for a divide (≥2)

Ports:
- clk  in  1  clock
- resetn  in  1  reset; one clock, asynchronous, active-low
- i_busy  in  1  instruction fetch in flight (ireq issued, iresp.data_ok not yet seen)
- d_wait  in  1  memory stage dreq outstanding
- fd_rs1, fd_rs2  in  5 each  source registers of the instruction in FD
- fd_use_rs1, fd_use_rs2  in  1 each  the FD instruction reads that source
- de_is_load  in  1  the instruction in EX is a load
- de_rd  in  5  destination register of the EX instruction
- ex_redirect  in  1  the EX instruction resolved a taken/mispredicted control transfer (level, held while in EX)
- ex_target  in  XLEN  redirect target
- mdu_start  in  1  the EX instruction is mul/div (level, held while in EX)
- mdu_is_div  in  1  select DIV_LAT, else MUL_LAT
- stall_o  out  4  `{fd,de,em,mw}` hold enables
- flush_o  out  4  `{fd,de,em,mw}` bubble-insert enables
- pc_stall  out  1  PC register hold
- pc_redirect  out  1  load PC from pc_target this cycle
- pc_target  out  XLEN  redirect target
- redirect_pending  out  1  FSM in R_WAIT
- mdu_busy  out  1  multi-cycle op still executing

## Operation
- Load-use hazard `lu` is `de_is_load && de_rd != 0 && ((fd_use_rs1 && fd_rs1 == de_rd) || (fd_use_rs2 && fd_rs2 == de_rd))`.
- MDU counter `cnt` (6 bits) and flag `hold`:
  - When `cnt == 0 && mdu_start && !hold`: mdu_busy=1 and cnt ← LAT-1 (LAT is DIV_LAT if mdu_is_div, else MUL_LAT).
  - When cnt > 1: mdu_busy=1 and cnt decrements.
  - When cnt == 1: mdu_busy=0 (completion cycle) and cnt ← 0. If stall_o.de is also asserted this cycle, hold ← 1.
  - hold clears on the first cycle with stall_o.de=0. While hold=1, mdu_start is ignored.
  - cnt counts regardless of d_wait.
- Redirect FSM, states R_IDLE and R_WAIT:
  - "fire" means R_IDLE && ex_redirect && stall_o.de=0.
  - fire with i_busy=0: pc_redirect=1 and pc_target=ex_target; stay in R_IDLE.
  - fire with i_busy=1: latch tgt ← ex_target and go to R_WAIT.
  - In R_WAIT, when i_busy=0 && d_wait=0: pc_redirect=1, pc_target=tgt, go to R_IDLE.
  - In R_WAIT, ex_redirect is ignored.
- Enables are evaluated in priority order; the first match wins, and any output not listed is 0:
  1. d_wait: stall pc, fd, de, em; flush mw.
  2. mdu_busy: stall pc, fd, de; flush em.
  3. fire, or R_WAIT: flush fd and de. Additionally, pc_stall=1 unless pc_redirect=1.
  4. lu: stall pc and fd; flush de.
  5. i_busy: stall pc; flush fd.
- pc_target is 0 whenever pc_redirect=0.

## Timing
- Reset (asynchronous, resetn=0) state: R_IDLE, cnt=0, hold=0, tgt=0.
- Reset output values: stall_o=0, flush_o=0, pc_stall=0, pc_redirect=0, pc_target=0, redirect_pending=0, mdu_busy=0.
- All outputs are combinational from the current state and inputs; state updates on the posedge clk.
- An undeferred redirect has zero latency: pc_redirect is asserted in the same cycle ex_redirect is seen.
- A deferred redirect asserts pc_redirect in the first cycle where i_busy=0 and d_wait=0.
- A mul/div occupies EX for exactly LAT cycles when there is no d_wait: LAT-1 cycles with mdu_busy=1, followed by one completion cycle.
- Reset asserted mid-operation aborts the counter and the FSM immediately; a pending target is discarded.
- d_wait asserted while in R_WAIT keeps the FSM in R_WAIT, even if i_busy falls.

## Test plan
- Load-use: de_is_load=1, de_rd=5, fd_rs1=5, fd_use_rs1=1 → stall_o=4'b1000, flush_o=4'b0100, pc_stall=1. With de_rd=0 → no stall.
- Multiply: mdu_start=1, mdu_is_div=0 held, MUL_LAT=3 → mdu_busy=1 for 2 cycles with flush_o.em=1, 3rd cycle mdu_busy=0, and no restart.
- Divide under d_wait: DIV_LAT=33, d_wait=1 during cycles 30-35 → completion at cycle 33, hold=1, no restart when d_wait drops with mdu_start still high.
- Immediate redirect: ex_redirect=1, ex_target=0x8000_0040, i_busy=0 → pc_redirect=1, pc_target=0x8000_0040, flush_o=4'b1100, FSM stays in R_IDLE.
- Deferred redirect: ex_redirect=1 with i_busy=1 for 4 more cycles → redirect_pending=1 and flush_o=4'b1100 every cycle, then pc_redirect=1 with the latched target on the cycle i_busy=0.
- Async reset while in R_WAIT and with cnt=10 → all outputs 0 immediately, and cnt=0 / R_IDLE after release.

Source files
------------

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: per-stage stall/flush enables, PC control,
// the multi-cycle mul/div latency counter and the deferred-redirect FSM.
module hazard_unit #(
    parameter int XLEN    = 64,
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 33
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            i_busy,
    input  logic            d_wait,
    input  logic [4:0]      fd_rs1,
    input  logic [4:0]      fd_rs2,
    input  logic            fd_use_rs1,
    input  logic            fd_use_rs2,
    input  logic            de_is_load,
    input  logic [4:0]      de_rd,
    input  logic            ex_redirect,
    input  logic [XLEN-1:0] ex_target,
    input  logic            mdu_start,
    input  logic            mdu_is_div,
    output logic [3:0]      stall_o,
    output logic [3:0]      flush_o,
    output logic            pc_stall,
    output logic            pc_redirect,
    output logic [XLEN-1:0] pc_target,
    output logic            redirect_pending,
    output logic            mdu_busy
);

    localparam logic [5:0] MUL_M1 = 6'(MUL_LAT - 1);
    localparam logic [5:0] DIV_M1 = 6'(DIV_LAT - 1);

    typedef enum logic {R_IDLE, R_WAIT} rstate_e;

    rstate_e         state_q, state_d;
    logic [5:0]      cnt_q, cnt_d;
    logic            hold_q, hold_d;
    logic [XLEN-1:0] tgt_q, tgt_d;

    logic            lu, start_ok, busy, stall_de, fire, redir, in_wait;
    logic [3:0]      st, fl;
    logic            ps;

    always_comb begin
        lu       = de_is_load && (de_rd != 5'd0) &&
                   ((fd_use_rs1 && fd_rs1 == de_rd) || (fd_use_rs2 && fd_rs2 == de_rd));
        start_ok = (cnt_q == 6'd0) && mdu_start && !hold_q;
        busy     = start_ok || (cnt_q > 6'd1);
        // stall_o.de is only raised by the d_wait and mdu_busy rows
        stall_de = d_wait || busy;
        in_wait  = (state_q == R_WAIT);
        fire     = !in_wait && ex_redirect && !stall_de;
        redir    = (fire && !i_busy) || (in_wait && !i_busy && !d_wait);

        st = 4'b0000;
        fl = 4'b0000;
        ps = 1'b0;
        if (d_wait) begin
            st = 4'b1110;
            fl = 4'b0001;
            ps = 1'b1;
        end else if (busy) begin
            st = 4'b1100;
            fl = 4'b0010;
            ps = 1'b1;
        end else if (fire || in_wait) begin
            fl = 4'b1100;
            ps = !redir;
        end else if (lu) begin
            st = 4'b1000;
            fl = 4'b0100;
            ps = 1'b1;
        end else if (i_busy) begin
            fl = 4'b1000;
            ps = 1'b1;
        end

        cnt_d = cnt_q;
        if (start_ok)           cnt_d = mdu_is_div ? DIV_M1 : MUL_M1;
        else if (cnt_q > 6'd1)  cnt_d = cnt_q - 6'd1;
        else if (cnt_q == 6'd1) cnt_d = 6'd0;

        // hold keeps a finished op from re-issuing while EX is frozen on it
        hold_d = hold_q;
        if (cnt_q == 6'd1 && stall_de) hold_d = 1'b1;
        else if (!stall_de)            hold_d = 1'b0;

        state_d = state_q;
        tgt_d   = tgt_q;
        if (fire && i_busy) begin
            state_d = R_WAIT;
            tgt_d   = ex_target;
        end else if (in_wait && !i_busy && !d_wait) begin
            state_d = R_IDLE;
        end

        // outputs read zero for as long as reset is held
        stall_o          = resetn ? st : 4'b0000;
        flush_o          = resetn ? fl : 4'b0000;
        pc_stall         = resetn && ps;
        pc_redirect      = resetn && redir;
        pc_target        = (resetn && redir) ? (in_wait ? tgt_q : ex_target) : '0;
        redirect_pending = resetn && in_wait;
        mdu_busy         = resetn && busy;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= R_IDLE;
            cnt_q   <= 6'd0;
            hold_q  <= 1'b0;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            tgt_q   <= tgt_d;
        end
    end

endmodule
